if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk  input  1  rising-edge clock; i_rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have the following further ports, one per line:
- i_pc  input  32  current fetch PC from the PC register.
- i_instr  input  32  instruction word read from instruction memory at i_pc.
- i_ifidwrite  input  1  1 = IF/ID register loads; 0 = IF/ID register holds (hazard stall).
- i_flush  input  1  1 = the IF/ID register becomes a bubble at the next edge.
- i_jump  input  1  the ID-stage instruction is a jump.
- i_branch_taken  input  1  the ID-stage branch is resolved taken.
- o_next_pc  output  32  next-PC value driven back to the PC register.
- o_pc_plus4  output  32  registered IF/ID PC+4.
- o_instr  output  32  registered IF/ID instruction.
- o_valid  output  1  the IF/ID register holds a real instruction, not a bubble.
REQ-003 The block SHALL have no parameters; all widths are fixed at 32 bits.

Function
REQ-004 The block SHALL compute pc_plus4 = i_pc + 32'd4 combinationally, with modulo-2^32 wrap (0xFFFFFFFC -> 0x00000000).
REQ-005 The block SHALL compute the branch target = o_pc_plus4 + ({{14{o_instr[15]}}, o_instr[15:0], 2'b00}), modulo 2^32.
REQ-006 The block SHALL compute the jump target = {o_pc_plus4[31:28], o_instr[25:0], 2'b00}.
REQ-007 o_next_pc SHALL be combinational with priority: i_jump -> jump target; else i_branch_taken -> branch target; else pc_plus4.
REQ-008 At each rising edge, the IF/ID register SHALL update with priority: i_rst, then i_flush, then ~i_ifidwrite (hold), then load.
REQ-009 On load, the IF/ID register SHALL capture o_pc_plus4 <= pc_plus4, o_instr <= i_instr and o_valid <= 1.
REQ-010 On flush, the IF/ID register SHALL take o_instr <= 32'h0 (nop), o_valid <= 0 and o_pc_plus4 <= pc_plus4.
REQ-011 On hold, all IF/ID outputs SHALL keep their previous values.
REQ-012 When i_flush and ~i_ifidwrite are asserted in the same cycle, flush SHALL win.
REQ-013 Latency SHALL be one cycle: an instruction presented on i_instr at edge N appears on o_instr after edge N.
REQ-014 o_next_pc SHALL depend only on the current inputs and register state, with no extra pipeline delay.
REQ-015 When i_jump and i_branch_taken are asserted together, the jump target SHALL be selected.

Reset
REQ-016 On i_rst=1 sampled at a rising edge, the block SHALL set o_pc_plus4=0, o_instr=0 and o_valid=0.
REQ-017 Reset SHALL override flush, stall and load in the same cycle.
REQ-018 Reset asserted mid-stall SHALL discard the held instruction.
REQ-019 While i_rst=1, o_next_pc SHALL still follow REQ-007 using the reset register values (pc_plus4 path when i_jump=i_branch_taken=0).

Configuration
REQ-020 Macro IF_ID_PERF_EN SHALL control optional performance counters.
REQ-021 With IF_ID_PERF_EN defined, the block SHALL add outputs o_stall_cnt (32) and o_flush_cnt (32), both reset to 0.
REQ-022 o_stall_cnt SHALL increment on each edge where ~i_rst & ~i_flush & ~i_ifidwrite.
REQ-023 o_flush_cnt SHALL increment on each edge where ~i_rst & i_flush.
REQ-024 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 Without IF_ID_PERF_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Reset then load: i_rst=1 for one edge, then i_pc=0x100, i_instr=0x8C220004, i_ifidwrite=1 -> after the next edge o_pc_plus4=0x104, o_instr=0x8C220004, o_valid=1.
REQ-027 Stall: hold i_ifidwrite=0 for 2 edges while i_instr changes -> o_instr unchanged; with IF_ID_PERF_EN, o_stall_cnt=2.
REQ-028 Branch: o_pc_plus4=0x104, o_instr[15:0]=0xFFFE, i_branch_taken=1 -> o_next_pc=0x0FC; with i_flush=1 at the edge -> o_valid=0, o_instr=0.
REQ-029 Jump priority: o_pc_plus4=0x40000008, o_instr[25:0]=0x0000010, i_jump=1 and i_branch_taken=1 -> o_next_pc=0x40000040.
REQ-030 Wrap and conflict: i_pc=0xFFFFFFFC -> o_next_pc=0x00000000; i_flush=1 with i_ifidwrite=0 -> bubble loaded, and with IF_ID_PERF_EN o_flush_cnt increments while o_stall_cnt does not.

Source files
------------

// File: rtl/if_id_stage.sv
// IF stage next-PC selection plus the IF/ID pipeline register.
// Define IF_ID_PERF_EN to add stall/flush performance counters (o_stall_cnt, o_flush_cnt).
module if_id_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_ifidwrite,
  input  logic        i_flush,
  input  logic        i_jump,
  input  logic        i_branch_taken,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_instr,
  output logic        o_valid
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4      = i_pc + 32'd4;
  // Branch and jump targets come from the instruction already sitting in ID.
  assign branch_off    = {{14{o_instr[15]}}, o_instr[15:0], 2'b00};
  assign branch_target = o_pc_plus4 + branch_off;
  assign jump_target   = {o_pc_plus4[31:28], o_instr[25:0], 2'b00};

  always_comb begin
    o_next_pc = pc_plus4;
    if (i_jump) begin
      o_next_pc = jump_target;
    end else if (i_branch_taken) begin
      o_next_pc = branch_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pc_plus4 <= 32'h0;
      o_instr    <= 32'h0;
      o_valid    <= 1'b0;
    end else if (i_flush) begin
      o_pc_plus4 <= pc_plus4;
      o_instr    <= 32'h0;
      o_valid    <= 1'b0;
    end else if (i_ifidwrite) begin
      o_pc_plus4 <= pc_plus4;
      o_instr    <= i_instr;
      o_valid    <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= 32'h0;
      o_flush_cnt <= 32'h0;
    end else begin
      // A flush takes precedence, so a flushed stall cycle is not a stall.
      if (i_flush) begin
        o_flush_cnt <= o_flush_cnt + 32'd1;
      end else if (!i_ifidwrite) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: reference model, per-cycle compare and directed literal checks.
module tb_if_id_stage;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        i_ifidwrite;
  logic        i_flush;
  logic        i_jump;
  logic        i_branch_taken;
  logic [31:0] o_next_pc;
  logic [31:0] o_pc_plus4;
  logic [31:0] o_instr;
  logic        o_valid;
`ifdef IF_ID_PERF_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;
`endif

  int n_checks;
  int n_pass;
  bit cmp_en;

  // model state
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;
  longint      m_stalls;
  longint      m_flushes;

  if_id_stage dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pc           (i_pc),
    .i_instr        (i_instr),
    .i_ifidwrite    (i_ifidwrite),
    .i_flush        (i_flush),
    .i_jump         (i_jump),
    .i_branch_taken (i_branch_taken),
    .o_next_pc      (o_next_pc),
    .o_pc_plus4     (o_pc_plus4),
    .o_instr        (o_instr),
    .o_valid        (o_valid)
`ifdef IF_ID_PERF_EN
    ,
    .o_stall_cnt    (o_stall_cnt),
    .o_flush_cnt    (o_flush_cnt)
`endif
  );

  // clock / reset block
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Next PC from plain arithmetic on the model's registered state.
  function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic jump,
                                                input logic br);
    longint off;
    if (jump) return (m_pc4 & 32'hF000_0000) | (32'(m_instr[25:0]) * 4);
    if (br) begin
      off = longint'($signed(m_instr[15:0])) * 4;
      return 32'((longint'(m_pc4) + off) % 64'h1_0000_0000);
    end
    return 32'((longint'(pc) + 4) % 64'h1_0000_0000);
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_pc4 = 0; m_instr = 0; m_valid = 0; m_stalls = 0; m_flushes = 0;
    end else if (i_flush) begin
      m_pc4 = 32'((longint'(i_pc) + 4) % 64'h1_0000_0000);
      m_instr = 0; m_valid = 0;
      m_flushes = (m_flushes + 1) % 64'h1_0000_0000;
    end else if (!i_ifidwrite) begin
      m_stalls = (m_stalls + 1) % 64'h1_0000_0000;
    end else begin
      m_pc4 = 32'((longint'(i_pc) + 4) % 64'h1_0000_0000);
      m_instr = i_instr; m_valid = 1;
    end
  end

  // compare process: every negedge once the first reset edge has passed
  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("cmp_next_pc", o_next_pc, model_next_pc(i_pc, i_jump, i_branch_taken));
      check("cmp_pc_plus4", o_pc_plus4, m_pc4);
      check("cmp_instr", o_instr, m_instr);
      check("cmp_valid", 32'(o_valid), 32'(m_valid));
`ifdef IF_ID_PERF_EN
      check("cmp_stall_cnt", o_stall_cnt, 32'(m_stalls));
      check("cmp_flush_cnt", o_flush_cnt, 32'(m_flushes));
`endif
    end
  end

  // driver tasks: inputs change 2ns after the active edge
  task automatic drive(input logic rst, input logic [31:0] pc, input logic [31:0] instr,
                       input logic wr, input logic fl, input logic j, input logic br);
    i_rst = rst; i_pc = pc; i_instr = instr; i_ifidwrite = wr;
    i_flush = fl; i_jump = j; i_branch_taken = br;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  typedef struct packed {
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wr;
    logic        fl;
    logic        j;
    logic        br;
  } vec_t;

  vec_t vecs[10];

  initial begin
    n_checks = 0; n_pass = 0; cmp_en = 0;
    m_pc4 = 0; m_instr = 0; m_valid = 0; m_stalls = 0; m_flushes = 0;

    // reset held over two edges; o_next_pc follows pc+4 during reset
    drive(1, 32'h100, 32'h0, 1, 0, 0, 0);
    tick();
    cmp_en = 1;
    #1;
    check("rst_pc_plus4", o_pc_plus4, 32'h0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_next_pc", o_next_pc, 32'h104);
    tick();

    // reset then load
    drive(0, 32'h100, 32'h8C22_0004, 1, 0, 0, 0);
    tick(); #1;
    check("load_pc_plus4", o_pc_plus4, 32'h104);
    check("load_instr", o_instr, 32'h8C22_0004);
    check("load_valid", 32'(o_valid), 32'h1);

    // two stall edges with changing instruction
    drive(0, 32'h104, 32'h1111_1111, 0, 0, 0, 0);
    tick();
    i_instr = 32'h2222_2222;
    tick(); #1;
    check("stall_instr", o_instr, 32'h8C22_0004);
    check("stall_pc_plus4", o_pc_plus4, 32'h104);
`ifdef IF_ID_PERF_EN
    check("stall_cnt", o_stall_cnt, 32'd2);
`endif

    // taken branch with offset -2 words, then flush
    drive(0, 32'h100, 32'h1000_FFFE, 1, 0, 0, 0);
    tick();
    i_branch_taken = 1; i_pc = 32'h104; #1;
    check("branch_next_pc", o_next_pc, 32'h0000_00FC);
    i_flush = 1; i_pc = 32'hFC;
    tick(); #1;
    check("flush_valid", 32'(o_valid), 32'h0);
    check("flush_instr", o_instr, 32'h0);
    check("flush_pc_plus4", o_pc_plus4, 32'h100);

    // jump wins over branch
    drive(0, 32'h4000_0004, 32'h0800_0010, 1, 0, 0, 0);
    tick();
    i_jump = 1; i_branch_taken = 1; #1;
    check("jump_prio_next_pc", o_next_pc, 32'h4000_0040);
    i_jump = 0; #1;
    check("branch_fwd_next_pc", o_next_pc, 32'h4000_0048);

    // pc wrap, then flush against stall
    drive(0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0, 0, 0, 0); #1;
    check("wrap_next_pc", o_next_pc, 32'h0);
    i_flush = 1;
    tick(); #1;
    check("conflict_valid", 32'(o_valid), 32'h0);
    check("conflict_instr", o_instr, 32'h0);
    check("conflict_pc_plus4", o_pc_plus4, 32'h0);
`ifdef IF_ID_PERF_EN
    check("conflict_flush_cnt", o_flush_cnt, 32'd2);
    check("conflict_stall_cnt", o_stall_cnt, 32'd2);
`endif

    // reset during a stall discards the held instruction
    drive(0, 32'h200, 32'hABCD_0123, 1, 0, 0, 0);
    tick();
    drive(0, 32'h204, 32'h0, 0, 0, 0, 0);
    tick();
    drive(1, 32'h204, 32'h5555_5555, 0, 1, 0, 0);
    tick(); #1;
    check("rst_stall_instr", o_instr, 32'h0);
    check("rst_stall_valid", 32'(o_valid), 32'h0);
`ifdef IF_ID_PERF_EN
    check("rst_stall_cnt", o_stall_cnt, 32'h0);
`endif

    // mixed directed vectors, checked by the compare process
    vecs[0] = '{0, 32'h0000_1000, 32'h1234_8000, 1, 0, 0, 0};
    vecs[1] = '{0, 32'h0000_1004, 32'h0, 0, 0, 0, 1};
    vecs[2] = '{0, 32'h7FFF_FFFC, 32'h0BFF_FFFF, 1, 0, 0, 0};
    vecs[3] = '{0, 32'h8000_0000, 32'h0, 1, 0, 1, 0};
    vecs[4] = '{0, 32'hF000_0000, 32'h03FF_FFFF, 1, 0, 0, 1};
    vecs[5] = '{0, 32'hF000_0004, 32'h0, 0, 1, 1, 1};
    vecs[6] = '{0, 32'h0000_0040, 32'h0000_7FFF, 1, 0, 0, 0};
    vecs[7] = '{0, 32'h0000_0044, 32'h1, 0, 0, 0, 1};
    vecs[8] = '{1, 32'h0000_0048, 32'h2, 1, 1, 1, 1};
    vecs[9] = '{0, 32'hFFFF_FFF8, 32'h3, 1, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].instr, vecs[i].wr, vecs[i].fl,
            vecs[i].j, vecs[i].br);
      tick();
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0, 0);
    tick();
    tick();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
